// File: rtl/reg_wb_sched.sv
// -----------------------------------------------------------------------------
// reg_wb_sched
// Write-back scheduler for the register file. This block is the only driver of
// the file's write port. It merges load returns and ALU results onto that port.
// ALU results that lose the port to a load are parked in a small in-order FIFO.
// A per-register busy scoreboard is exported, and the issue stage is stalled
// on read-after-write hazards.
//
// Ports:
//   clk, reset                  clock; synchronous active-high reset
//   alu_wr_en/addr, alu_dat     ALU write request (held by requester on stall)
//   ld_issue, ld_addr           load issued to data memory, destination reg
//   ld_ret_valid, ld_ret_dat    load data returning this cycle
//   rd_addrA, rd_addrB          issue-stage read pointers (hazard check)
//   wr_en, wr_addr, dat_out     registered register-file write port
//   busy                        per-register "write pending" scoreboard
//   stall                       combinational hold for the issue stage
//   ld_pending                  a load is outstanding
//   q_count                     ALU FIFO occupancy
//   err                         one-cycle pulse on a protocol violation
// -----------------------------------------------------------------------------
module reg_wb_sched #(
    parameter int DW = 8,
    parameter int PW = 3,
    parameter int QD = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     alu_wr_en,
    input  logic [PW-1:0]            alu_wr_addr,
    input  logic [DW-1:0]            alu_dat,
    input  logic                     ld_issue,
    input  logic [PW-1:0]            ld_addr,
    input  logic                     ld_ret_valid,
    input  logic [DW-1:0]            ld_ret_dat,
    input  logic [PW-1:0]            rd_addrA,
    input  logic [PW-1:0]            rd_addrB,
    output logic                     wr_en,
    output logic [PW-1:0]            wr_addr,
    output logic [DW-1:0]            dat_out,
    output logic [(2**PW)-1:0]       busy,
    output logic                     stall,
    output logic                     ld_pending,
    output logic [$clog2(QD+1)-1:0]  q_count,
    output logic                     err
);

    localparam int             CW   = $clog2(QD + 1);
    localparam logic [CW-1:0]  QD_C = CW'(QD);
    // Registers 0 and 1 are hardwired; anything at or below this is illegal.
    localparam logic [PW-1:0]  HW_MAX = PW'(1);

    // ALU FIFO, kept compacted at index 0 (head) so order is implicit.
    logic [PW-1:0] fa_q [QD];
    logic [DW-1:0] fd_q [QD];
    logic [PW-1:0] fa_d [QD];
    logic [DW-1:0] fd_d [QD];
    logic [CW-1:0] cnt_q, cnt_d;

    logic          ldp_q, ldp_d;
    logic [PW-1:0] lda_q, lda_d;

    logic          wen_q, wen_d;
    logic [PW-1:0] wa_q,  wa_d;
    logic [DW-1:0] wd_q,  wd_d;
    logic          err_q, err_d;

    logic [(2**PW)-1:0] busy_c;
    logic               full;
    logic               stall_c;

    logic          ld_win, alu_acc, alu_ok, pop, byp, push, fifo_hit, ld_ok;
    logic [CW-1:0] cnt_mid;

    // Scoreboard: queued ALU writes, the outstanding load, and the write that
    // is on the port this cycle (not yet visible in the file).
    always_comb begin
        busy_c = '0;
        for (int i = 0; i < QD; i++) begin
            if (CW'(i) < cnt_q) busy_c[fa_q[i]] = 1'b1;
        end
        if (ldp_q) busy_c[lda_q] = 1'b1;
        if (wen_q) busy_c[wa_q]  = 1'b1;
    end

    always_comb begin
        full    = (cnt_q == QD_C);
        stall_c = full
                | (busy_c[rd_addrA] && (rd_addrA > HW_MAX))
                | (busy_c[rd_addrB] && (rd_addrB > HW_MAX));
    end

    // Port arbitration: load return > FIFO head > bypassed ALU write.
    always_comb begin
        ld_win  = ld_ret_valid && ldp_q;
        alu_acc = alu_wr_en && !stall_c;
        // An accepted write to a hardwired register is consumed and dropped.
        alu_ok  = alu_acc && (alu_wr_addr > HW_MAX);
        pop     = !ld_win && (cnt_q != '0);
        byp     = !ld_win && (cnt_q == '0) && alu_ok;
        push    = alu_ok && !byp;

        // A new load may not target a register with an older ALU write still
        // queued (including one being queued now): its return could overtake.
        fifo_hit = push && (alu_wr_addr == ld_addr);
        for (int i = 0; i < QD; i++) begin
            if ((CW'(i) < cnt_q) && (fa_q[i] == ld_addr)) fifo_hit = 1'b1;
        end
        // A returning load frees the tracker in the same cycle.
        ld_ok = ld_issue && (ld_addr > HW_MAX) && (!ldp_q || ld_win) && !fifo_hit;

        err_d = (alu_acc && (alu_wr_addr <= HW_MAX))
              | (ld_issue && !ld_ok)
              | (ld_ret_valid && !ldp_q);

        ldp_d = ldp_q;
        lda_d = lda_q;
        if (ld_ok) begin
            ldp_d = 1'b1;
            lda_d = ld_addr;
        end else if (ld_win) begin
            ldp_d = 1'b0;
        end

        // Address/data hold their last value when no write is issued.
        wen_d = ld_win | pop | byp;
        wa_d  = wa_q;
        wd_d  = wd_q;
        if (ld_win) begin
            wa_d = lda_q;
            wd_d = ld_ret_dat;
        end else if (pop) begin
            wa_d = fa_q[0];
            wd_d = fd_q[0];
        end else if (byp) begin
            wa_d = alu_wr_addr;
            wd_d = alu_dat;
        end

        for (int i = 0; i < QD; i++) begin
            fa_d[i] = fa_q[i];
            fd_d[i] = fd_q[i];
        end
        if (pop) begin
            for (int i = 0; i < QD - 1; i++) begin
                fa_d[i] = fa_q[i+1];
                fd_d[i] = fd_q[i+1];
            end
        end
        cnt_mid = cnt_q - CW'(pop);
        if (push) begin
            for (int i = 0; i < QD; i++) begin
                if (CW'(i) == cnt_mid) begin
                    fa_d[i] = alu_wr_addr;
                    fd_d[i] = alu_dat;
                end
            end
        end
        cnt_d = cnt_mid + CW'(push);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < QD; i++) begin
                fa_q[i] <= '0;
                fd_q[i] <= '0;
            end
            cnt_q <= '0;
            ldp_q <= 1'b0;
            lda_q <= '0;
            wen_q <= 1'b0;
            wa_q  <= '0;
            wd_q  <= '0;
            err_q <= 1'b0;
        end else begin
            for (int i = 0; i < QD; i++) begin
                fa_q[i] <= fa_d[i];
                fd_q[i] <= fd_d[i];
            end
            cnt_q <= cnt_d;
            ldp_q <= ldp_d;
            lda_q <= lda_d;
            wen_q <= wen_d;
            wa_q  <= wa_d;
            wd_q  <= wd_d;
            err_q <= err_d;
        end
    end

    assign wr_en      = wen_q;
    assign wr_addr    = wa_q;
    assign dat_out    = wd_q;
    assign busy       = busy_c;
    assign stall      = stall_c;
    assign ld_pending = ldp_q;
    assign q_count    = cnt_q;
    assign err        = err_q;

endmodule

// File: tb/tb_reg_wb_sched.sv
module tb_reg_wb_sched;

    localparam int QD = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       alu_wr_en = 1'b0;
    logic [2:0] alu_wr_addr = '0;
    logic [7:0] alu_dat = '0;
    logic       ld_issue = 1'b0;
    logic [2:0] ld_addr = '0;
    logic       ld_ret_valid = 1'b0;
    logic [7:0] ld_ret_dat = '0;
    logic [2:0] rd_addrA = '0;
    logic [2:0] rd_addrB = '0;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [7:0] dat_out;
    logic [7:0] busy;
    logic       stall;
    logic       ld_pending;
    logic [1:0] q_count;
    logic       err;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    reg_wb_sched #(.DW(8), .PW(3), .QD(QD)) dut (
        .clk(clk), .reset(reset),
        .alu_wr_en(alu_wr_en), .alu_wr_addr(alu_wr_addr), .alu_dat(alu_dat),
        .ld_issue(ld_issue), .ld_addr(ld_addr),
        .ld_ret_valid(ld_ret_valid), .ld_ret_dat(ld_ret_dat),
        .rd_addrA(rd_addrA), .rd_addrB(rd_addrB),
        .wr_en(wr_en), .wr_addr(wr_addr), .dat_out(dat_out),
        .busy(busy), .stall(stall), .ld_pending(ld_pending),
        .q_count(q_count), .err(err)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    int   mq_a[$];
    int   mq_d[$];
    bit   m_ldp;
    int   m_lda;
    bit   m_wen;
    int   m_wa, m_wd;
    bit   m_err;
    bit   m_held;

    function automatic logic [7:0] m_busy();
        logic [7:0] b = '0;
        foreach (mq_a[i]) b[mq_a[i]] = 1'b1;
        if (m_ldp) b[m_lda] = 1'b1;
        if (m_wen) b[m_wa]  = 1'b1;
        return b;
    endfunction

    function automatic bit m_stall(input logic [7:0] b);
        return (mq_a.size() == QD)
            || (b[rd_addrA] && rd_addrA > 1)
            || (b[rd_addrB] && rd_addrB > 1);
    endfunction

    task automatic m_clear();
        mq_a.delete(); mq_d.delete();
        m_ldp = 0; m_lda = 0; m_wen = 0; m_wa = 0; m_wd = 0; m_err = 0;
    endtask

    // Advance the model over one clock edge using the inputs now applied.
    task automatic m_step();
        bit st, ldwin, acc, ok, hit, ldok, issued;
        int na, nd;
        st     = m_stall(m_busy());
        m_held = alu_wr_en && (st || reset);
        if (reset) begin
            m_clear();
            return;
        end
        ldwin  = ld_ret_valid && m_ldp;
        acc    = alu_wr_en && !st;
        ok     = acc && (alu_wr_addr > 1);
        hit    = 0;
        foreach (mq_a[i]) if (mq_a[i] == int'(ld_addr)) hit = 1;
        issued = 0; na = 0; nd = 0;
        if (ldwin) begin
            issued = 1; na = m_lda; nd = ld_ret_dat;
        end else if (mq_a.size() > 0) begin
            issued = 1; na = mq_a.pop_front(); nd = mq_d.pop_front();
        end else if (ok) begin
            issued = 1; na = alu_wr_addr; nd = alu_dat; ok = 0;
        end
        if (ok) begin
            if (alu_wr_addr == ld_addr) hit = 1;
            mq_a.push_back(alu_wr_addr);
            mq_d.push_back(alu_dat);
        end
        ldok  = ld_issue && ld_addr > 1 && (!m_ldp || ldwin) && !hit;
        m_err = (acc && alu_wr_addr <= 1) || (ld_issue && !ldok) || (ld_ret_valid && !m_ldp);
        if (ldok) begin
            m_ldp = 1; m_lda = ld_addr;
        end else if (ldwin) begin
            m_ldp = 0;
        end
        m_wen = issued;
        if (issued) begin
            m_wa = na; m_wd = nd;
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (cycle %0d): got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    task automatic m_compare();
        logic [7:0] b;
        b = m_busy();
        chk("wr_en",      wr_en,      m_wen);
        chk("wr_addr",    wr_addr,    m_wa);
        chk("dat_out",    dat_out,    m_wd);
        chk("busy",       busy,       b);
        chk("stall",      stall,      m_stall(b));
        chk("ld_pending", ld_pending, m_ldp);
        chk("q_count",    q_count,    mq_a.size());
        chk("err",        err,        m_err);
    endtask

    // One cycle: compare at the falling edge, step the model, settle after rise.
    task automatic tick();
        @(negedge clk); #1;
        m_compare();
        m_step();
        @(posedge clk); #1;
        cyc++;
    endtask

    task automatic idle();
        alu_wr_en = 0; ld_issue = 0; ld_ret_valid = 0; reset = 0;
    endtask

    task automatic alu(input int a, input int d);
        alu_wr_en = 1; alu_wr_addr = a[2:0]; alu_dat = d[7:0];
    endtask

    initial begin
        // reset
        reset = 1;
        repeat (2) @(posedge clk);
        #1;
        reset = 0;
        m_clear();
        m_held = 0;
        chk("rst.wr_en", wr_en, 0);
        chk("rst.wr_addr", wr_addr, 0);
        chk("rst.dat_out", dat_out, 0);
        chk("rst.q_count", q_count, 0);
        chk("rst.busy", busy, 0);
        chk("rst.err", err, 0);
        chk("rst.ld_pending", ld_pending, 0);

        // bypass
        alu(5, 8'h3C); tick(); idle();
        chk("byp.wr_en", wr_en, 1);
        chk("byp.wr_addr", wr_addr, 5);
        chk("byp.dat", dat_out, 8'h3C);
        chk("byp.busy", busy, 8'h20);
        tick();
        chk("byp.wr_en_off", wr_en, 0);
        chk("byp.busy_off", busy, 0);

        // load return collides with ALU write
        ld_issue = 1; ld_addr = 2; tick(); idle();
        chk("cf.ld_pending", ld_pending, 1);
        chk("cf.busy", busy, 8'h04);
        tick(); tick();
        ld_ret_valid = 1; ld_ret_dat = 8'hA5; alu(6, 8'h11); tick(); idle();
        chk("cf.wr1_addr", wr_addr, 2);
        chk("cf.wr1_dat", dat_out, 8'hA5);
        chk("cf.q1", q_count, 1);
        tick();
        chk("cf.wr2_addr", wr_addr, 6);
        chk("cf.wr2_dat", dat_out, 8'h11);
        chk("cf.q0", q_count, 0);

        // FIFO fill via back-to-back load returns
        ld_issue = 1; ld_addr = 2; tick();
        ld_ret_valid = 1; ld_ret_dat = 8'h01; alu(3, 8'h33); tick();
        ld_ret_dat = 8'h02; alu(4, 8'h44); tick();
        chk("full.q2", q_count, 2);
        chk("full.stall", stall, 1);
        ld_issue = 0; ld_ret_dat = 8'h03; alu(5, 8'h55); tick();
        chk("full.held_q", q_count, 2);
        ld_ret_valid = 0; tick();
        chk("full.d3", wr_addr, 3);
        tick();
        chk("full.d4", wr_addr, 4);
        idle(); tick();
        chk("full.d5", wr_addr, 5);
        chk("full.d5dat", dat_out, 8'h55);

        // RAW hazard on r7
        ld_issue = 1; ld_addr = 2; tick(); idle();
        ld_ret_valid = 1; ld_ret_dat = 8'h22; alu(7, 8'h77); rd_addrA = 7; tick(); idle();
        chk("hz.queued_stall", stall, 1);
        tick();
        chk("hz.write7", wr_addr, 7);
        chk("hz.write_stall", stall, 1);
        tick();
        chk("hz.clear", stall, 0);
        rd_addrA = 0; #1;
        chk("hz.r0", stall, 0);

        // protocol errors
        alu(1, 8'hFF); tick(); idle();
        chk("er.alu_err", err, 1);
        chk("er.alu_nowr", wr_en, 0);
        tick();
        chk("er.once", err, 0);
        ld_issue = 1; ld_addr = 3; tick();
        ld_addr = 4; tick(); idle();
        chk("er.ld_err", err, 1);
        chk("er.busy3", busy, 8'h08);
        ld_ret_valid = 1; ld_ret_dat = 8'h5A; tick(); idle();
        chk("er.ld_dest", wr_addr, 3);

        // reset with a full queue and a pending load
        ld_issue = 1; ld_addr = 2; tick();
        ld_ret_valid = 1; alu(3, 8'h13); tick();
        alu(4, 8'h14); tick(); idle();
        chk("rm.q2", q_count, 2);
        chk("rm.ldp", ld_pending, 1);
        reset = 1; tick(); idle();
        chk("rm.wr_en", wr_en, 0);
        chk("rm.wr_addr", wr_addr, 0);
        chk("rm.q", q_count, 0);
        chk("rm.busy", busy, 0);
        chk("rm.ldp0", ld_pending, 0);
        ld_ret_valid = 1; tick(); idle();
        chk("rm.err", err, 1);
        chk("rm.nowr", wr_en, 0);

        // randomized traffic
        for (int n = 0; n < 4000; n++) begin
            reset = ($urandom_range(0, 299) == 0);
            if (!m_held) begin
                alu_wr_en   = ($urandom_range(0, 2) != 0);
                alu_wr_addr = ($urandom_range(0, 11) == 0) ? 3'($urandom_range(0, 1))
                                                           : 3'($urandom_range(2, 7));
                alu_dat     = 8'($urandom);
            end
            ld_issue     = ($urandom_range(0, 3) == 0);
            ld_addr      = ($urandom_range(0, 11) == 0) ? 3'($urandom_range(0, 1))
                                                        : 3'($urandom_range(2, 7));
            ld_ret_valid = m_ldp ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 19) == 0);
            ld_ret_dat   = 8'($urandom);
            rd_addrA     = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'd0;
            rd_addrB     = ($urandom_range(0, 5) == 0) ? 3'($urandom) : 3'd0;
            tick();
        end
        idle();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
